// File: rtl/phy_rx_pkg.sv
// Shared definitions for the two-lane PHY receive sync controller: lane FSM
// encoding and default comma/sync parameters.
package phy_rx_pkg;

  typedef logic [1:0] lane_state_t;

  localparam lane_state_t ST_SEARCH = 2'd0;
  localparam lane_state_t ST_ALIGN  = 2'd1;
  localparam lane_state_t ST_ACTIVE = 2'd2;

  localparam logic [7:0] COM_BYTE_DEF   = 8'hBC;
  localparam int         SYNC_COUNT_DEF = 4;
`ifdef PHY_RX_SYNC_LOSS_EN
  localparam int         LOSS_THR_DEF   = 4;
`endif

endpackage

// File: rtl/phy_rx_lane_sync.sv
// One receive lane: bit deserializer, byte-boundary counter, comma alignment FSM
// and payload hold register. Loss-of-sync tracking exists only with PHY_RX_SYNC_LOSS_EN.
module phy_rx_lane_sync
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COM_BYTE   = COM_BYTE_DEF,
  parameter int         SYNC_COUNT = SYNC_COUNT_DEF
`ifdef PHY_RX_SYNC_LOSS_EN
  ,
  parameter int         LOSS_THR   = LOSS_THR_DEF
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_in,
  input  logic       clr,
  output logic [7:0] hold,
  output logic       pending,
  output logic       load,
  output logic       active
);

  localparam logic [3:0] SYNC_TGT = 4'(SYNC_COUNT);
`ifdef PHY_RX_SYNC_LOSS_EN
  localparam logic [3:0] LOSS_TGT = 4'(LOSS_THR);
`endif

  logic [7:0]  sr_r;
  logic [2:0]  bcnt_r;
  lane_state_t state_r;
  logic [3:0]  com_cnt_r;
  logic [7:0]  hold_r;
  logic        pending_r;
  logic        active_r;

  lane_state_t state_s;
  logic [3:0]  com_cnt_s;
  logic [2:0]  bcnt_s;
  logic        load_s;
  logic        drop_s;
  logic        comma_s;
  logic        boundary_s;

`ifdef PHY_RX_SYNC_LOSS_EN
  logic [3:0]  loss_cnt_r;
  logic [3:0]  loss_cnt_s;
`endif

  assign comma_s    = (sr_r == COM_BYTE);
  assign boundary_s = (bcnt_r == 3'd7);

  // Alignment FSM next-state; the boundary counter is only re-phased on first comma in SEARCH
  always_comb begin
    state_s   = state_r;
    com_cnt_s = com_cnt_r;
    bcnt_s    = bcnt_r + 3'd1;
    load_s    = 1'b0;
    drop_s    = 1'b0;
`ifdef PHY_RX_SYNC_LOSS_EN
    loss_cnt_s = loss_cnt_r;
`endif
    case (state_r)
      ST_SEARCH: begin
        if (comma_s) begin
          bcnt_s    = 3'd0;
          com_cnt_s = 4'd1;
          if (SYNC_TGT == 4'd1) begin
            state_s = ST_ACTIVE;
          end else begin
            state_s = ST_ALIGN;
          end
        end else begin
          com_cnt_s = 4'd0;
        end
      end
      ST_ALIGN: begin
        if (boundary_s && comma_s) begin
          com_cnt_s = com_cnt_r + 4'd1;
          if (com_cnt_s == SYNC_TGT) begin
            state_s = ST_ACTIVE;
          end else begin
            state_s = ST_ALIGN;
          end
        end else if (boundary_s) begin
          state_s   = ST_SEARCH;
          com_cnt_s = 4'd0;
        end else begin
          state_s = ST_ALIGN;
        end
      end
      ST_ACTIVE: begin
        if (boundary_s && !comma_s) begin
          load_s = 1'b1;
        end else begin
          load_s = 1'b0;
        end
`ifdef PHY_RX_SYNC_LOSS_EN
        // A comma seen off the byte grid means the line has slipped
        if (comma_s && boundary_s) begin
          loss_cnt_s = 4'd0;
        end else if (comma_s) begin
          loss_cnt_s = loss_cnt_r + 4'd1;
          if (loss_cnt_s == LOSS_TGT) begin
            state_s    = ST_SEARCH;
            com_cnt_s  = 4'd0;
            loss_cnt_s = 4'd0;
            drop_s     = 1'b1;
          end else begin
            state_s = ST_ACTIVE;
          end
        end else begin
          loss_cnt_s = loss_cnt_r;
        end
`endif
      end
      default: begin
        state_s   = ST_SEARCH;
        com_cnt_s = 4'd0;
      end
    endcase
  end

  // Shift register, boundary counter and FSM state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_r      <= 8'h00;
      bcnt_r    <= 3'd0;
      state_r   <= ST_SEARCH;
      com_cnt_r <= 4'd0;
      active_r  <= 1'b0;
`ifdef PHY_RX_SYNC_LOSS_EN
      loss_cnt_r <= 4'd0;
`endif
    end else begin
      sr_r      <= {sr_r[6:0], data_in};
      bcnt_r    <= bcnt_s;
      state_r   <= state_s;
      com_cnt_r <= com_cnt_s;
      active_r  <= (state_s == ST_ACTIVE);
`ifdef PHY_RX_SYNC_LOSS_EN
      loss_cnt_r <= loss_cnt_s;
`endif
    end
  end

  // Payload hold register; a fresh byte beats a same-cycle grant clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r    <= 8'h00;
      pending_r <= 1'b0;
    end else begin
      if (load_s) begin
        hold_r <= sr_r;
      end
      if (drop_s) begin
        pending_r <= 1'b0;
      end else if (load_s) begin
        pending_r <= 1'b1;
      end else if (clr) begin
        pending_r <= 1'b0;
      end
    end
  end

  assign hold    = hold_r;
  assign pending = pending_r;
  assign load    = load_s;
  assign active  = active_r;

endmodule

// File: rtl/phy_rx_sync_ctrl.sv
// Two-lane receive sync controller with round-robin byte arbiter and sticky overflow.
// Optional loss-of-sync detection is enabled by defining PHY_RX_SYNC_LOSS_EN.
module phy_rx_sync_ctrl
  import phy_rx_pkg::*;
#(
  parameter logic [7:0] COM_BYTE   = COM_BYTE_DEF,
  parameter int         SYNC_COUNT = SYNC_COUNT_DEF
`ifdef PHY_RX_SYNC_LOSS_EN
  ,
  parameter int         LOSS_THR   = LOSS_THR_DEF
`endif
) (
  input  logic       clk_32f,
  input  logic       reset,
  input  logic       data_in0,
  input  logic       data_in1,
  output logic [7:0] data_out,
  output logic       valid_out,
  output logic       lane_out,
  output logic       active0,
  output logic       active1,
  output logic       overflow
);

  logic [7:0] hold0_s;
  logic [7:0] hold1_s;
  logic       pend0_s;
  logic       pend1_s;
  logic       load0_s;
  logic       load1_s;
  logic       grant0_s;
  logic       grant1_s;
  logic       gsel_s;
  logic       any_s;

  logic [7:0] data_out_r;
  logic       valid_out_r;
  logic       lane_out_r;
  logic       last_grant_r;
  logic       overflow_r;

  phy_rx_lane_sync #(
    .COM_BYTE   (COM_BYTE),
    .SYNC_COUNT (SYNC_COUNT)
`ifdef PHY_RX_SYNC_LOSS_EN
    ,
    .LOSS_THR   (LOSS_THR)
`endif
  ) u_lane0 (
    .clk     (clk_32f),
    .rst_n   (reset),
    .data_in (data_in0),
    .clr     (grant0_s),
    .hold    (hold0_s),
    .pending (pend0_s),
    .load    (load0_s),
    .active  (active0)
  );

  phy_rx_lane_sync #(
    .COM_BYTE   (COM_BYTE),
    .SYNC_COUNT (SYNC_COUNT)
`ifdef PHY_RX_SYNC_LOSS_EN
    ,
    .LOSS_THR   (LOSS_THR)
`endif
  ) u_lane1 (
    .clk     (clk_32f),
    .rst_n   (reset),
    .data_in (data_in1),
    .clr     (grant1_s),
    .hold    (hold1_s),
    .pending (pend1_s),
    .load    (load1_s),
    .active  (active1)
  );

  // Round-robin selection: contention goes to the lane not served last
  always_comb begin
    gsel_s = last_grant_r;
    any_s  = 1'b0;
    if (pend0_s && pend1_s) begin
      gsel_s = ~last_grant_r;
      any_s  = 1'b1;
    end else if (pend0_s) begin
      gsel_s = 1'b0;
      any_s  = 1'b1;
    end else if (pend1_s) begin
      gsel_s = 1'b1;
      any_s  = 1'b1;
    end else begin
      gsel_s = last_grant_r;
      any_s  = 1'b0;
    end
  end

  assign grant0_s = any_s & ~gsel_s;
  assign grant1_s = any_s & gsel_s;

  // Registered output stage and sticky overflow
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      data_out_r   <= 8'h00;
      valid_out_r  <= 1'b0;
      lane_out_r   <= 1'b0;
      last_grant_r <= 1'b1;
      overflow_r   <= 1'b0;
    end else begin
      valid_out_r <= any_s;
      if (any_s) begin
        data_out_r   <= gsel_s ? hold1_s : hold0_s;
        lane_out_r   <= gsel_s;
        last_grant_r <= gsel_s;
      end
      if ((load0_s && pend0_s && !grant0_s) || (load1_s && pend1_s && !grant1_s)) begin
        overflow_r <= 1'b1;
      end
    end
  end

  assign data_out  = data_out_r;
  assign valid_out = valid_out_r;
  assign lane_out  = lane_out_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_phy_rx_sync_ctrl.sv
// Directed bench for phy_rx_sync_ctrl: reset, comma sync, arbitration, resync,
// asynchronous reset and (macro-dependent) loss of sync.
module tb_phy_rx_sync_ctrl;

  logic       clk_32f;
  logic       reset;
  logic       data_in0;
  logic       data_in1;
  logic [7:0] data_out;
  logic       valid_out;
  logic       lane_out;
  logic       active0;
  logic       active1;
  logic       overflow;

  int vectors;
  int miscompares;
  int cyc;
  int rise0;
  int rise1;
  int fall0;
  int         log_cyc[$];
  logic       log_lane[$];
  logic [7:0] log_data[$];

`ifdef PHY_RX_SYNC_LOSS_EN
  localparam int LOSS_EXP_N    = 4;
  localparam int LOSS_EXP_FALL = 67;
`else
  localparam int LOSS_EXP_N    = 6;
  localparam int LOSS_EXP_FALL = -1;
`endif

  phy_rx_sync_ctrl dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in0  (data_in0),
    .data_in1  (data_in1),
    .data_out  (data_out),
    .valid_out (valid_out),
    .lane_out  (lane_out),
    .active0   (active0),
    .active1   (active1),
    .overflow  (overflow)
  );

  initial clk_32f = 1'b0;
  always #5 clk_32f = ~clk_32f;

  // one bit per lane; outputs observed 1 time unit after the edge
  task automatic step(input logic b0, input logic b1);
    data_in0 = b0;
    data_in1 = b1;
    @(posedge clk_32f);
    #1;
    cyc++;
    if (valid_out === 1'b1) begin
      log_cyc.push_back(cyc);
      log_lane.push_back(lane_out);
      log_data.push_back(data_out);
    end
    if (active0 === 1'b1 && rise0 < 0) rise0 = cyc;
    if (active0 === 1'b0 && rise0 >= 0 && fall0 < 0) fall0 = cyc;
    if (active1 === 1'b1 && rise1 < 0) rise1 = cyc;
  endtask

  task automatic send(input logic [7:0] b0, input logic [7:0] b1);
    for (int i = 7; i >= 0; i--) step(b0[i], b1[i]);
  endtask

  task automatic hold_reset();
    reset    = 1'b0;
    data_in0 = 1'b1;
    data_in1 = 1'b1;
    repeat (8) @(posedge clk_32f);
    #1;
  endtask

  task automatic release_reset();
    cyc   = -1;
    rise0 = -1;
    rise1 = -1;
    fall0 = -1;
    log_cyc.delete();
    log_lane.delete();
    log_data.delete();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    hold_reset();
    vectors += 8;
    if (data_out !== 8'h00) begin miscompares++; $display("FAIL reset_data_out got %h want 00", data_out); end
    if (valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", valid_out); end
    if (lane_out !== 1'b0) begin miscompares++; $display("FAIL reset_lane got %b want 0", lane_out); end
    if (active0 !== 1'b0) begin miscompares++; $display("FAIL reset_active0 got %b want 0", active0); end
    if (active1 !== 1'b0) begin miscompares++; $display("FAIL reset_active1 got %b want 0", active1); end
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow got %b want 0", overflow); end
    if (dut.u_lane0.sr_r !== 8'h00) begin miscompares++; $display("FAIL reset_sr0 got %h want 00", dut.u_lane0.sr_r); end
    if (dut.u_lane1.sr_r !== 8'h00) begin miscompares++; $display("FAIL reset_sr1 got %h want 00", dut.u_lane1.sr_r); end
    release_reset();
  endtask

  task automatic test_sync();
    for (int n = 0; n < 4; n++) send(8'hBC, 8'hBC);
    // 4th comma boundary is cycle 31; nothing active yet
    step(1'b0, 1'b0);
    vectors += 3;
    if (rise0 !== 32) begin miscompares++; $display("FAIL sync_rise0 got %0d want 32", rise0); end
    if (rise1 !== 32) begin miscompares++; $display("FAIL sync_rise1 got %0d want 32", rise1); end
    if (log_cyc.size() !== 0) begin miscompares++; $display("FAIL sync_no_valid got %0d want 0", log_cyc.size()); end
  endtask

  task automatic test_payload();
    int         ec[5];
    logic       el[5];
    logic [7:0] ed[5];
    ec = '{41, 42, 49, 57, 58};
    el = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    ed = '{8'h5A, 8'h5A, 8'h11, 8'h44, 8'h33};
    // first bit (0 of 0x5A) was already sent by test_sync
    for (int i = 6; i >= 0; i--) step(8'h5A >> i, 8'h5A >> i);
    send(8'h11, 8'hBC);
    send(8'h33, 8'h44);
    send(8'hBC, 8'hBC);
    vectors++;
    if (log_cyc.size() !== 5) begin miscompares++; $display("FAIL payload_count got %0d want 5", log_cyc.size()); end
    for (int i = 0; i < 5; i++) begin
      if (i < log_cyc.size()) begin
        vectors++;
        if (log_cyc[i] !== ec[i] || log_lane[i] !== el[i] || log_data[i] !== ed[i]) begin
          miscompares++;
          $display("FAIL payload_%0d got cyc=%0d lane=%b data=%h want cyc=%0d lane=%b data=%h",
                   i, log_cyc[i], log_lane[i], log_data[i], ec[i], el[i], ed[i]);
        end
      end
    end
    vectors++;
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL payload_overflow got %b want 0", overflow); end
  endtask

  task automatic test_resync();
    hold_reset();
    release_reset();
    send(8'hBC, 8'hBC);
    send(8'hBC, 8'hBC);
    send(8'hBC, 8'hBC);
    send(8'h12, 8'hBC);
    for (int n = 0; n < 5; n++) send(8'hBC, 8'hBC);
    vectors += 3;
    if (rise0 !== 64) begin miscompares++; $display("FAIL resync_rise0 got %0d want 64", rise0); end
    if (rise1 !== 32) begin miscompares++; $display("FAIL resync_rise1 got %0d want 32", rise1); end
    if (log_cyc.size() !== 0) begin miscompares++; $display("FAIL resync_no_valid got %0d want 0", log_cyc.size()); end
  endtask

  task automatic test_reset_mid();
    send(8'h77, 8'h88);
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    vectors += 2;
    if (valid_out !== 1'b1) begin miscompares++; $display("FAIL mid_pre_valid got %b want 1", valid_out); end
    if (data_out !== 8'h77) begin miscompares++; $display("FAIL mid_pre_data got %h want 77", data_out); end
    reset = 1'b0;
    #2;
    vectors += 5;
    if (active0 !== 1'b0) begin miscompares++; $display("FAIL mid_active0 got %b want 0", active0); end
    if (active1 !== 1'b0) begin miscompares++; $display("FAIL mid_active1 got %b want 0", active1); end
    if (valid_out !== 1'b0) begin miscompares++; $display("FAIL mid_valid got %b want 0", valid_out); end
    if (overflow !== 1'b0) begin miscompares++; $display("FAIL mid_overflow got %b want 0", overflow); end
    if (data_out !== 8'h00) begin miscompares++; $display("FAIL mid_data got %h want 00", data_out); end
  endtask

  task automatic test_loss();
    int         ec[6];
    logic [7:0] ed[6];
    ec = '{41, 49, 57, 65, 73, 81};
    ed = '{8'h17, 8'h97, 8'h97, 8'h97, 8'h80, 8'h00};
    hold_reset();
    release_reset();
    for (int n = 0; n < 4; n++) send(8'hBC, 8'hBC);
    // 0x17 0x97.. 0x80 place a comma 3 bits past each boundary
    send(8'h17, 8'hBC);
    send(8'h97, 8'hBC);
    send(8'h97, 8'hBC);
    send(8'h97, 8'hBC);
    send(8'h80, 8'hBC);
    send(8'h00, 8'hBC);
    send(8'h00, 8'hBC);
    vectors += 3;
    if (rise0 !== 32) begin miscompares++; $display("FAIL loss_rise0 got %0d want 32", rise0); end
    if (fall0 !== LOSS_EXP_FALL) begin miscompares++; $display("FAIL loss_fall0 got %0d want %0d", fall0, LOSS_EXP_FALL); end
    if (log_cyc.size() !== LOSS_EXP_N) begin
      miscompares++;
      $display("FAIL loss_count got %0d want %0d", log_cyc.size(), LOSS_EXP_N);
    end
    for (int i = 0; i < LOSS_EXP_N; i++) begin
      if (i < log_cyc.size()) begin
        vectors++;
        if (log_cyc[i] !== ec[i] || log_lane[i] !== 1'b0 || log_data[i] !== ed[i]) begin
          miscompares++;
          $display("FAIL loss_%0d got cyc=%0d lane=%b data=%h want cyc=%0d lane=0 data=%h",
                   i, log_cyc[i], log_lane[i], log_data[i], ec[i], ed[i]);
        end
      end
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = -1;
    rise0       = -1;
    rise1       = -1;
    fall0       = -1;
    reset       = 1'b0;
    data_in0    = 1'b0;
    data_in1    = 1'b0;
    test_reset();
    test_sync();
    test_payload();
    test_resync();
    test_reset_mid();
    test_loss();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
